// File: rtl/aim_chunk_sequencer.sv
// Chunk sequencer for the associative-index-match datapath: stages 32 codes per chunk
// from the word buffer, kicks the matcher, waits for finish (with timeout), repeats.
module aim_chunk_sequencer #(
  parameter int                 W_LEN    = 256,
  parameter int                 WORD_BW  = 5,
  parameter logic [WORD_BW-1:0] PAD_CODE = 5'h1F,
  parameter int                 TIMEOUT  = 64,
  localparam int AW = $clog2(W_LEN),
  localparam int NW = AW + 1,
  localparam int CW = (W_LEN > 32) ? $clog2(W_LEN / 32) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [NW-1:0]              i_num_words,
  input  logic [3:0]                 i_ite,
  output logic                       o_wmem_ren,
  output logic [AW-1:0]              o_wmem_addr,
  input  logic [WORD_BW-1:0]         i_wmem_rdata,
  output logic [31:0][WORD_BW-1:0]   o_word,
  output logic                       o_aim_start,
  output logic [3:0]                 o_aim_ite,
  input  logic                       i_aim_finish,
  output logic [CW-1:0]              o_chunk_idx,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_timeout
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT, S_NEXT, S_DONE} state_t;

  state_t                     r_state;
  logic [NW-1:0]              r_num;
  logic [3:0]                 r_ite;
  logic [CW-1:0]              r_chunk;
  logic [5:0]                 r_cnt;
  logic [TW-1:0]              r_wait;
  logic                       r_rd_vld;
  logic                       r_timeout;
  logic [31:0][WORD_BW-1:0]   r_word;

  // One extra address bit so the end-of-list compare on the last chunk cannot wrap.
  logic [NW-1:0] w_base, w_next_base, w_addr_full;
  logic          w_ren;
  logic [4:0]    w_slot;

  assign w_base      = NW'({r_chunk, 5'd0});
  assign w_next_base = w_base + NW'(32);
  assign w_addr_full = w_base + NW'(r_cnt);
  assign w_ren       = (r_state == S_LOAD) && !r_cnt[5] && (w_addr_full < r_num);
  assign w_slot      = 5'(r_cnt - 6'd1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_num     <= '0;
      r_ite     <= '0;
      r_chunk   <= '0;
      r_cnt     <= '0;
      r_wait    <= '0;
      r_rd_vld  <= 1'b0;
      r_timeout <= 1'b0;
      r_word    <= {32{PAD_CODE}};
    end else begin
      r_rd_vld <= w_ren;
      case (r_state)
        S_IDLE: if (i_start && !i_abort) begin
          r_num     <= i_num_words;
          r_ite     <= i_ite;
          r_chunk   <= '0;
          r_cnt     <= '0;
          r_timeout <= 1'b0;
          r_state   <= (i_num_words == '0) ? S_DONE : S_LOAD;
        end
        S_LOAD: begin
          // Slot k-1 lands one cycle after its read; unread slots become padding.
          if (r_cnt != 6'd0)
            r_word[w_slot] <= r_rd_vld ? i_wmem_rdata : PAD_CODE;
          if (r_cnt == 6'd32) r_state <= S_KICK;
          else                r_cnt   <= r_cnt + 6'd1;
        end
        S_KICK: begin
          r_wait  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_aim_finish) r_state <= S_NEXT;
          else if (r_wait == TW'(TIMEOUT - 1)) begin
            r_timeout <= 1'b1;
            r_state   <= S_DONE;
          end else r_wait <= r_wait + TW'(1);
        end
        S_NEXT: begin
          if (w_next_base >= r_num) r_state <= S_DONE;
          else begin
            r_chunk <= r_chunk + CW'(1);
            r_cnt   <= '0;
            r_state <= S_LOAD;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (i_abort && r_state != S_IDLE) r_state <= S_IDLE;
    end
  end

  assign o_wmem_ren  = w_ren;
  assign o_wmem_addr = w_addr_full[AW-1:0];
  assign o_word      = r_word;
  assign o_aim_start = (r_state == S_KICK);
  assign o_aim_ite   = r_ite;
  assign o_chunk_idx = r_chunk;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = (r_state == S_DONE);
  assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_aim_chunk_sequencer.sv
// Scoreboard bench for aim_chunk_sequencer: expected read addresses and staged banks
// are queued at job start and checked as the DUT issues reads and matcher kicks.
module tb_aim_chunk_sequencer;
  localparam logic [4:0] PAD = 5'h1F;

  logic              i_clk = 1'b0, i_rst_n = 1'b0;
  logic              i_start = 1'b0, i_abort = 1'b0, i_aim_finish = 1'b0;
  logic [8:0]        i_num_words = '0;
  logic [3:0]        i_ite = '0;
  logic              o_wmem_ren, o_aim_start, o_busy, o_done, o_timeout;
  logic [7:0]        o_wmem_addr;
  logic [4:0]        wmem_rdata = '0;
  logic [31:0][4:0]  o_word;
  logic [3:0]        o_aim_ite;
  logic [2:0]        o_chunk_idx;

  aim_chunk_sequencer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_num_words(i_num_words), .i_ite(i_ite), .o_wmem_ren(o_wmem_ren),
    .o_wmem_addr(o_wmem_addr), .i_wmem_rdata(wmem_rdata), .o_word(o_word),
    .o_aim_start(o_aim_start), .o_aim_ite(o_aim_ite), .i_aim_finish(i_aim_finish),
    .o_chunk_idx(o_chunk_idx), .o_busy(o_busy), .o_done(o_done), .o_timeout(o_timeout));

  always #5 i_clk = ~i_clk;

  int total = 0, bad = 0;
  int n_start = 0, n_done = 0, n_ren = 0;
  bit resp_en = 1'b1;
  logic [4:0]       mem [256];
  logic [7:0]       exp_addr [$];
  logic [31:0][4:0] exp_bank [$];

  always @(posedge i_clk) if (o_wmem_ren) wmem_rdata <= mem[o_wmem_addr];

  // Scoreboard monitor
  initial forever begin
    @(negedge i_clk);
    if (o_wmem_ren) begin
      n_ren++;
      total++;
      if (exp_addr.size() == 0) begin
        bad++; $display("FAIL rd_addr unexpected read got=%0d", o_wmem_addr);
      end else begin
        logic [7:0] ea;
        ea = exp_addr.pop_front();
        if (o_wmem_addr !== ea) begin
          bad++; $display("FAIL rd_addr got=%0d exp=%0d", o_wmem_addr, ea);
        end
      end
    end
    if (o_aim_start) begin
      n_start++;
      total++;
      if (exp_bank.size() == 0) begin
        bad++; $display("FAIL bank unexpected aim_start");
      end else begin
        logic [31:0][4:0] eb;
        eb = exp_bank.pop_front();
        if (o_word !== eb) begin
          bad++; $display("FAIL bank got=%h exp=%h", o_word, eb);
        end
      end
    end
    if (o_done) n_done++;
  end

  // Matcher model: finish in the 6th WAIT cycle
  initial forever begin
    @(negedge i_clk);
    if (o_aim_start && resp_en) begin
      repeat (6) @(posedge i_clk);
      #1 i_aim_finish = 1'b1;
      @(posedge i_clk);
      #1 i_aim_finish = 1'b0;
    end
  end

  task automatic push_job(input int nw);
    int nchunk;
    nchunk = (nw + 31) / 32;
    for (int c = 0; c < nchunk; c++) begin
      logic [31:0][4:0] b;
      for (int s = 0; s < 32; s++) begin
        int a;
        a = c * 32 + s;
        if (a < nw) begin
          b[s] = mem[a];
          exp_addr.push_back(8'(a));
        end else b[s] = PAD;
      end
      exp_bank.push_back(b);
    end
  endtask

  // Pulse i_start; returns cycle count, IDLE cycle through DONE cycle inclusive.
  task automatic run_job(input int nw, input logic [3:0] ite, output int cyc);
    push_job(nw);
    @(negedge i_clk);
    i_start = 1'b1; i_num_words = 9'(nw); i_ite = ite;
    cyc = 1;
    do begin
      @(negedge i_clk);
      i_start = 1'b0;
      cyc++;
    end while (!o_done && cyc < 3000);
    total++;
    if (!o_done) begin bad++; $display("FAIL done_timeout nw=%0d no o_done", nw); end
    @(negedge i_clk);
  endtask

  task automatic flush_sb();
    exp_addr.delete();
    exp_bank.delete();
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    #12;
    total++;
    if ({o_busy, o_done, o_timeout, o_wmem_ren, o_aim_start} !== 5'b0 ||
        o_aim_ite !== 4'd0 || o_chunk_idx !== 3'd0) begin
      bad++; $display("FAIL reset_ctrl got busy=%b done=%b to=%b ren=%b st=%b exp all 0",
                      o_busy, o_done, o_timeout, o_wmem_ren, o_aim_start);
    end
    total++;
    if (o_word !== {32{PAD}}) begin bad++; $display("FAIL reset_word got=%h exp all 1f", o_word); end
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic check_job(input string nm, input int cyc, input int ecyc, input int s0,
                           input int d0, input int r0, input int es, input int er);
    total++;
    if (cyc !== ecyc) begin bad++; $display("FAIL %s_cycles got=%0d exp=%0d", nm, cyc, ecyc); end
    total++;
    if (n_start - s0 !== es) begin bad++; $display("FAIL %s_starts got=%0d exp=%0d", nm, n_start - s0, es); end
    total++;
    if (n_done - d0 !== 1) begin bad++; $display("FAIL %s_dones got=%0d exp=1", nm, n_done - d0); end
    total++;
    if (n_ren - r0 !== er) begin bad++; $display("FAIL %s_reads got=%0d exp=%0d", nm, n_ren - r0, er); end
    total++;
    if (exp_addr.size() != 0 || exp_bank.size() != 0) begin
      bad++; $display("FAIL %s_sb_left got=%0d/%0d exp=0/0", nm, exp_addr.size(), exp_bank.size());
    end
  endtask

  task automatic test_full64();
    int cyc, s0, d0, r0;
    s0 = n_start; d0 = n_done; r0 = n_ren;
    run_job(64, 4'd2, cyc);
    check_job("full64", cyc, 84, s0, d0, r0, 2, 64);
    total++;
    if (o_aim_ite !== 4'd2) begin bad++; $display("FAIL full64_ite got=%0d exp=2", o_aim_ite); end
  endtask

  task automatic test_partial40();
    int cyc, s0, d0, r0;
    s0 = n_start; d0 = n_done; r0 = n_ren;
    run_job(40, 4'd5, cyc);
    check_job("part40", cyc, 84, s0, d0, r0, 2, 40);
    total++;
    if (o_word[8] !== PAD || o_word[31] !== PAD || o_word[7] !== mem[39]) begin
      bad++; $display("FAIL part40_pad got w7=%h w8=%h w31=%h exp %h/1f/1f",
                      o_word[7], o_word[8], o_word[31], mem[39]);
    end
    total++;
    if (o_chunk_idx !== 3'd1) begin bad++; $display("FAIL part40_chunk got=%0d exp=1", o_chunk_idx); end
  endtask

  task automatic test_zero();
    int cyc, s0, d0, r0;
    s0 = n_start; d0 = n_done; r0 = n_ren;
    run_job(0, 4'd1, cyc);
    check_job("zero", cyc, 2, s0, d0, r0, 0, 0);
  endtask

  task automatic test_timeout();
    int cyc, s0, d0, r0;
    resp_en = 1'b0;
    s0 = n_start; d0 = n_done; r0 = n_ren;
    push_job(32);
    @(negedge i_clk);
    i_start = 1'b1; i_num_words = 9'd32; i_ite = 4'd4;
    cyc = 1;
    do begin
      @(negedge i_clk);
      i_start = 1'b0;
      cyc++;
    end while (!o_done && cyc < 3000);
    total++;
    if (o_timeout !== 1'b1) begin bad++; $display("FAIL timeout_flag got=%b exp=1", o_timeout); end
    @(negedge i_clk);
    check_job("timeout", cyc, 100, s0, d0, r0, 1, 32);
    total++;
    if (o_timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky got=%b exp=1", o_timeout); end
    resp_en = 1'b1;
    push_job(10);
    i_start = 1'b1; i_num_words = 9'd10; i_ite = 4'd1;
    @(negedge i_clk);
    i_start = 1'b0;
    total++;
    if (o_timeout !== 1'b0) begin bad++; $display("FAIL timeout_clear got=%b exp=0", o_timeout); end
    cyc = 0;
    while (!o_done && cyc < 3000) begin @(negedge i_clk); cyc++; end
    @(negedge i_clk);
    total++;
    if (o_timeout !== 1'b0 || exp_bank.size() != 0) begin
      bad++; $display("FAIL timeout_rerun got to=%b left=%0d exp 0/0", o_timeout, exp_bank.size());
    end
  endtask

  task automatic test_abort();
    int k, d0, cyc, s0, r0;
    d0 = n_done;
    push_job(64);
    @(negedge i_clk);
    i_start = 1'b1; i_num_words = 9'd64; i_ite = 4'd3;
    @(negedge i_clk);
    i_start = 1'b0;
    k = 0;
    while (!(o_wmem_ren && o_wmem_addr == 8'd10) && k < 100) begin @(negedge i_clk); k++; end
    total++;
    if (k >= 100) begin bad++; $display("FAIL abort_reach got=no addr 10 exp=addr 10"); end
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    total++;
    if (o_busy !== 1'b0 || o_wmem_ren !== 1'b0) begin
      bad++; $display("FAIL abort_idle got busy=%b ren=%b exp 0/0", o_busy, o_wmem_ren);
    end
    flush_sb();
    repeat (10) @(negedge i_clk);
    total++;
    if (n_done !== d0) begin bad++; $display("FAIL abort_nodone got=%0d exp=%0d", n_done - d0, 0); end
    s0 = n_start; d0 = n_done; r0 = n_ren;
    run_job(40, 4'd6, cyc);
    check_job("retrig", cyc, 84, s0, d0, r0, 2, 40);
  endtask

  task automatic test_start_busy();
    int k, d0, s0;
    d0 = n_done; s0 = n_start;
    push_job(64);
    @(negedge i_clk);
    i_start = 1'b1; i_num_words = 9'd64; i_ite = 4'd3;
    @(negedge i_clk);
    i_start = 1'b0;
    k = 0;
    while (!o_aim_start && k < 100) begin @(negedge i_clk); k++; end
    @(negedge i_clk);
    i_start = 1'b1; i_num_words = 9'd0; i_ite = 4'd7;
    @(negedge i_clk);
    i_start = 1'b0;
    total++;
    if (o_aim_ite !== 4'd3 || o_busy !== 1'b1) begin
      bad++; $display("FAIL busy_ite got ite=%0d busy=%b exp 3/1", o_aim_ite, o_busy);
    end
    k = 0;
    while (!o_done && k < 300) begin @(negedge i_clk); k++; end
    repeat (3) @(negedge i_clk);
    total++;
    if (n_done - d0 !== 1 || n_start - s0 !== 2 || o_aim_ite !== 4'd3) begin
      bad++; $display("FAIL busy_job got done=%0d starts=%0d ite=%0d exp 1/2/3",
                      n_done - d0, n_start - s0, o_aim_ite);
    end
  endtask

  task automatic test_async_reset();
    push_job(64);
    @(negedge i_clk);
    i_start = 1'b1; i_num_words = 9'd64; i_ite = 4'd2;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (8) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    total++;
    if (o_busy !== 1'b0 || o_wmem_ren !== 1'b0 || o_word !== {32{PAD}} || o_aim_ite !== 4'd0) begin
      bad++; $display("FAIL arst got busy=%b ren=%b w0=%h ite=%0d exp 0/0/1f/0",
                      o_busy, o_wmem_ren, o_word[0], o_aim_ite);
    end
    flush_sb();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 5'($urandom_range(0, 30));
    test_reset();
    test_full64();
    test_partial40();
    test_zero();
    test_timeout();
    test_abort();
    test_start_busy();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
